chacha_stream_xor: RTL and testbench
====================================

CHACHA_STREAM_XOR -- requirements
Module: chacha_stream_xor

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, reset, asynchronous, active-low.
REQ-002 SHALL have ports in_valid in 1, in_ready out 1, in_data in 128, in_keep in 16 (byte enables, bit i = in_data[8i+7:8i]), in_last in 1 (final word of message).
REQ-003 SHALL have ports out_valid out 1, out_ready in 1, out_data out 128, out_keep out 16, out_last out 1.
REQ-004 SHALL have ports ks_req out 1, keystream request; ks_valid in 1, one-cycle block strobe; ks_data in 512, keystream block.
REQ-005 SHALL have ports flush in 1, one-cycle abort pulse; busy out 1, high when any buffer is valid, a request is outstanding, or out_valid is high.

Function
REQ-006 Block buffer SHALL hold one 512-bit keystream block; lane index k (0..3) selects ks_data[128k+127:128k].
REQ-007 FSM states: IDLE (no block, no request), FETCH (ks_req high), STREAM (block valid), DRAIN (discarding an outstanding block after flush).
REQ-008 IDLE->FETCH when in_valid=1; ks_req SHALL be registered, asserted the edge entering FETCH, held until ks_valid sampled high, and deasserted on that same edge.
REQ-009 At most one request SHALL be outstanding; ks_valid while no request is outstanding SHALL be ignored.
REQ-010 FETCH->STREAM on ks_valid: block captured, k=0.
REQ-011 in_ready SHALL equal (state==STREAM) && (!out_valid || out_ready).
REQ-012 On an input handshake: out_data <= (in_data ^ lane k) with bytes where in_keep=0 forced to 0; out_keep <= in_keep; out_last <= in_last; out_valid <= 1. Latency: one cycle.
REQ-013 out_valid/out_data/out_keep/out_last SHALL hold stable until out_ready=1; out_valid clears on out_ready when no new input is accepted.
REQ-014 After a handshake with k=3 or in_last=1: block invalidated, k=0, STREAM->IDLE; unused lanes of a block are discarded when in_last=1 (each message starts on a fresh block).
REQ-015 Partial keep on non-last words SHALL still consume a full lane.
REQ-016 flush: clears block, k, out_valid; FETCH->DRAIN (ks_req drops, next ks_valid discarded, then IDLE); other states->IDLE; flush overrides a simultaneous input handshake.

Reset
REQ-017 While rst_n=0: state=IDLE, ks_req=0, out_valid=0, out_data=0, out_keep=0, out_last=0, in_ready=0, busy=0, k=0, buffers invalid; reset mid-request discards the outstanding block.

Configuration
REQ-018 With CHACHA_XOR_PREFETCH_EN defined: a second 512-bit shadow buffer SHALL exist; a request issues as soon as the active block is loaded and the shadow is empty; on the k=3 handshake the shadow becomes active with no bubble (in_ready stays high); in_last or flush discards the shadow (DRAIN if its request is still outstanding).
REQ-019 Without CHACHA_XOR_PREFETCH_EN: single buffer only, requests issue only per REQ-008; a one-request-latency bubble per 4 words is permitted.

Structure
REQ-020 Shared package chacha_pkg SHALL hold CHACHA_BLK_W=512, CHACHA_LANE_W=128, CHACHA_LANES=4 and the FSM state encoding.
REQ-021 One sub-module, chacha_ks_buffer (block/shadow storage, lane select, valid flags), SHALL be used; XOR, masking and FSM remain in chacha_stream_xor.

Verification
REQ-022 Block B0=512'h{16 words 32'h00010203+i}, in_data=0 x4 words, keep=16'hFFFF -> out_data = B0 lanes 0..3 in order, ks_req pulses exactly once.
REQ-023 6 words, last on word 6, in_keep=16'h00FF on word 6 -> words 5-6 use block 2 lanes 0-1, out_data[127:64]=0 on word 6, next message triggers a new request.
REQ-024 out_ready held 0 for 5 cycles mid-stream -> outputs stable, in_ready=0, no words lost or duplicated.
REQ-025 flush one cycle after ks_req rises, ks_valid 4 cycles later -> block discarded, busy returns 0, next message uses next supplied block at lane 0.
REQ-026 rst_n pulsed low during STREAM k=2 -> all outputs 0 next cycle, next message issues new request.
REQ-027 With CHACHA_XOR_PREFETCH_EN, 8 back-to-back words, out_ready=1 -> in_ready continuously high after first block arrives, 8 outputs on consecutive cycles.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared widths, FSM encoding and byte-mask helper for the ChaCha stream XOR block.
package chacha_pkg;
  localparam int CHACHA_BLK_W  = 512;
  localparam int CHACHA_LANE_W = 128;
  localparam int CHACHA_LANES  = 4;
  localparam int CHACHA_KEEP_W = CHACHA_LANE_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } chacha_state_e;

  typedef logic [CHACHA_LANES-1:0][CHACHA_LANE_W-1:0] chacha_blk_t;

  function automatic logic [CHACHA_LANE_W-1:0] byte_mask(input logic [CHACHA_KEEP_W-1:0] keep);
    logic [CHACHA_LANE_W-1:0] m;
    for (int i = 0; i < CHACHA_KEEP_W; i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction
endpackage

// File: rtl/chacha_ks_buffer.sv
// Keystream block storage, lane counter and valid flags.
// CHACHA_XOR_PREFETCH_EN adds a shadow block that is promoted when the active block runs out.
module chacha_ks_buffer
  import chacha_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     load,
  input  logic [CHACHA_BLK_W-1:0]  load_data,
  input  logic                     adv,
  input  logic                     adv_last,
  output logic                     act_valid,
  output logic                     shd_valid,
  output logic [1:0]               k,
  output logic [CHACHA_LANE_W-1:0] lane
);
  chacha_blk_t act_blk;
  logic        blk_done, act_nxt;

  assign blk_done = adv && ((k == 2'(CHACHA_LANES-1)) || adv_last);
  assign lane     = act_blk[k];

`ifdef CHACHA_XOR_PREFETCH_EN
  chacha_blk_t shd_blk;

  // a message end discards the prefetched block; a lane-3 roll promotes it
  assign act_nxt = blk_done ? (shd_valid && !adv_last) : act_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_blk   <= '0;
      shd_valid <= 1'b0;
    end else if (clear || (blk_done && adv_last)) begin
      shd_valid <= 1'b0;
    end else begin
      if (blk_done) shd_valid <= 1'b0;
      if (load && act_nxt) begin
        shd_blk   <= load_data;
        shd_valid <= 1'b1;
      end
    end
  end
`else
  assign act_nxt   = blk_done ? 1'b0 : act_valid;
  assign shd_valid = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_blk   <= '0;
      act_valid <= 1'b0;
      k         <= 2'd0;
    end else if (clear) begin
      act_valid <= 1'b0;
      k         <= 2'd0;
    end else begin
      if (adv) k <= blk_done ? 2'd0 : k + 2'd1;
      act_valid <= act_nxt;
`ifdef CHACHA_XOR_PREFETCH_EN
      if (blk_done && shd_valid && !adv_last) act_blk <= shd_blk;
`endif
      if (load && !act_nxt && !(blk_done && adv_last)) begin
        act_blk   <= load_data;
        act_valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/chacha_stream_xor.sv
// Streams 128-bit words through an XOR with ChaCha keystream lanes fetched on demand.
// Optional macro CHACHA_XOR_PREFETCH_EN enables a shadow block for bubble-free streaming.
module chacha_stream_xor
  import chacha_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHACHA_LANE_W-1:0] in_data,
  input  logic [CHACHA_KEEP_W-1:0] in_keep,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHACHA_LANE_W-1:0] out_data,
  output logic [CHACHA_KEEP_W-1:0] out_keep,
  output logic                     out_last,
  output logic                     ks_req,
  input  logic                     ks_valid,
  input  logic [CHACHA_BLK_W-1:0]  ks_data,
  input  logic                     flush,
  output logic                     busy
);
  chacha_state_e             state, state_n;
  logic                      ks_req_n, hs, ks_ack, msg_end;
  logic                      act_valid, shd_valid;
  logic [1:0]                k;
  logic [CHACHA_LANE_W-1:0]  lane;

  assign in_ready = (state == ST_STREAM) && (!out_valid || out_ready);
  assign hs       = in_valid && in_ready && !flush;
  assign ks_ack   = ks_valid && ks_req;
  assign msg_end  = hs && in_last;
  assign busy     = (state != ST_IDLE) || act_valid || shd_valid || out_valid;

  chacha_ks_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .load      (ks_ack && !flush),
    .load_data (ks_data),
    .adv       (hs),
    .adv_last  (in_last),
    .act_valid (act_valid),
    .shd_valid (shd_valid),
    .k         (k),
    .lane      (lane)
  );

`ifdef CHACHA_XOR_PREFETCH_EN
  logic blk_done;
  assign blk_done = hs && (k == 2'(CHACHA_LANES-1));
`endif

  always_comb begin
    state_n  = state;
    ks_req_n = ks_req;
    case (state)
      ST_IDLE:
        if (in_valid && !flush) begin
          state_n  = ST_FETCH;
          ks_req_n = 1'b1;
        end
      ST_FETCH:
        if (flush) begin
          ks_req_n = 1'b0;
          state_n  = ks_valid ? ST_IDLE : ST_DRAIN;
        end else if (ks_valid) begin
          ks_req_n = 1'b0;
          state_n  = ST_STREAM;
        end
      ST_STREAM:
        if (flush || msg_end) begin
          // a prefetch still in flight must be absorbed before the next message
          ks_req_n = 1'b0;
          state_n  = (ks_req && !ks_valid) ? ST_DRAIN : ST_IDLE;
        end else begin
`ifdef CHACHA_XOR_PREFETCH_EN
          if (ks_req) ks_req_n = !ks_valid;
          else        ks_req_n = !shd_valid || blk_done;
          if (blk_done && !shd_valid && !ks_ack) state_n = ST_FETCH;
`else
          if (hs && (k == 2'(CHACHA_LANES-1))) state_n = ST_IDLE;
`endif
        end
      ST_DRAIN:
        if (ks_valid) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ks_req <= 1'b0;
    end else begin
      state  <= state_n;
      ks_req <= ks_req_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (hs) begin
      out_valid <= 1'b1;
      out_data  <= (in_data ^ lane) & byte_mask(in_keep);
      out_keep  <= in_keep;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_chacha_stream_xor.sv
// Directed scoreboard bench for chacha_stream_xor with an auto-responding keystream source.
module tb_chacha_stream_xor;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [127:0] in_data, out_data;
  logic [15:0]  in_keep, out_keep;
  logic         ks_req, ks_valid, flush, busy;
  logic [511:0] ks_data;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  int    checks = 0, errors = 0;
  int    blk_idx = 0, req_rises = 0, ks_delay = 2;
  bit    ks_auto = 1'b1;

  always #5 clk = ~clk;

  chacha_stream_xor dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .ks_req(ks_req), .ks_valid(ks_valid), .ks_data(ks_data),
    .flush(flush), .busy(busy)
  );

  function automatic logic [511:0] blk(input int n);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = 32'h00010203 + 32'(i) + 32'(n) * 32'h01000000;
    return b;
  endfunction

  function automatic logic [127:0] lane_of(input int n, input int k);
    logic [511:0] b;
    b = blk(n);
    return b[128*k +: 128];
  endfunction

  function automatic logic [127:0] kmask(input logic [127:0] d, input logic [15:0] kp);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (kp[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  // keystream source: answers each request after ks_delay cycles with the next block
  initial begin
    ks_valid = 1'b0;
    ks_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && ks_auto && ks_req) begin
        repeat (ks_delay) @(negedge clk);
        ks_data  = blk(blk_idx);
        blk_idx++;
        ks_valid = 1'b1;
        @(negedge clk);
        ks_valid = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge ks_req);
    req_rises++;
  end

  // output monitor: a beat transfers at the next rising edge
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_out got %0h want none", out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", out_data, mon_e.data);
        chk("out_keep", out_keep, mon_e.keep);
        chk("out_last", out_last, mon_e.last);
      end
    end
  end

  // call at a falling edge; returns at the falling edge after the handshake
  task automatic send(input logic [127:0] d, input logic [15:0] kp, input bit lst,
                      input logic [127:0] ks_lane, output int n);
    beat_t e;
    n = 0;
    in_valid = 1'b1; in_data = d; in_keep = kp; in_last = lst;
    e.data = kmask(d ^ ks_lane, kp); e.keep = kp; e.last = lst;
    sb.push_back(e);
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $error("FAIL send_timeout got in_ready=%0b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $error("FAIL drain_timeout got %0d pending want 0", sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int r0, b0, n;
    logic [127:0] d;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
    out_ready = 1'b1; flush = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ks_req", ks_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

`ifdef CHACHA_XOR_PREFETCH_EN
    b0 = blk_idx; ks_delay = 1;
    for (int w = 0; w < 8; w++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 16'hFFFF, w == 7, (w < 4) ? lane_of(b0, w) : lane_of(b0 + 1, w - 4), n);
      if (w > 0) chk("pf_stall", n, 0);
    end
    wait_drain();
    chk("pf_busy", busy, 0);
`else
    // B0 with zero data returns the raw keystream lanes
    r0 = req_rises; b0 = blk_idx;
    chk("b0_word5", blk(b0) >> 160, blk(b0) >> 160);
    for (int w = 0; w < 4; w++) send('0, 16'hFFFF, w == 3, lane_of(b0, w), n);
    wait_drain();
    chk("t1_req_count", req_rises - r0, 1);
    chk("t1_busy", busy, 0);

    // six words spanning two blocks, partial keep on the last
    r0 = req_rises; b0 = blk_idx;
    for (int w = 0; w < 6; w++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, (w == 5) ? 16'h00FF : 16'hFFFF, w == 5, (w < 4) ? lane_of(b0, w) : lane_of(b0 + 1, w - 4), n);
    end
    wait_drain();
    chk("t2_req_count", req_rises - r0, 2);
    r0 = req_rises; b0 = blk_idx;
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 16'hFFFF, 1'b1, lane_of(b0, 0), n);
    wait_drain();
    chk("t3_req_count", req_rises - r0, 1);

    // back-pressure: outputs hold while out_ready is low
    b0 = blk_idx;
    d = 128'h0123456789abcdef_fedcba9876543210;
    send(d, 16'hFFFF, 1'b0, lane_of(b0, 0), n);
    out_ready = 1'b0;
    fork
      send(~d, 16'hFFFF, 1'b0, lane_of(b0, 1), n);
      begin
        repeat (5) begin
          #2;
          chk("t4_hold_data", out_data, kmask(d ^ lane_of(b0, 0), 16'hFFFF));
          chk("t4_hold_valid", out_valid, 1);
          chk("t4_in_ready", in_ready, 0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    send(d ^ 128'h5a, 16'hFFFF, 1'b0, lane_of(b0, 2), n);
    send(d ^ 128'ha5, 16'hFFFF, 1'b1, lane_of(b0, 3), n);
    wait_drain();

    // flush one cycle after the request, block arrives late and is dropped
    ks_auto = 1'b0; r0 = req_rises;
    in_valid = 1'b1; in_data = '1; in_keep = 16'hFFFF; in_last = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ks_req && n < 20) begin @(negedge clk); n++; end
    chk("t5_req_seen", ks_req, 1);
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("t5_req_drop", ks_req, 0);
    chk("t5_busy_drain", busy, 1);
    repeat (3) @(negedge clk);
    ks_data = blk(blk_idx); blk_idx++; ks_valid = 1'b1;
    @(negedge clk);
    ks_valid = 1'b0;
    #1;
    chk("t5_busy_idle", busy, 0);
    chk("t5_no_out", out_valid, 0);
    @(negedge clk);
    ks_auto = 1'b1;
    b0 = blk_idx;
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 16'hFFFF, 1'b1, lane_of(b0, 0), n);
    wait_drain();
    chk("t5_req_count", req_rises - r0, 2);

    // reset while streaming at lane 2
    b0 = blk_idx;
    send(128'h11, 16'hFFFF, 1'b0, lane_of(b0, 0), n);
    send(128'h22, 16'hFFFF, 1'b0, lane_of(b0, 1), n);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_out_keep", out_keep, 0);
    chk("t6_out_last", out_last, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_ks_req", ks_req, 0);
    chk("t6_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    r0 = req_rises; b0 = blk_idx;
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 16'hF0F0, 1'b1, lane_of(b0, 0), n);
    wait_drain();
    chk("t6_req_count", req_rises - r0, 1);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
